// File: rtl/dint_pkg.sv
// Shared types and constants for the deinterlacer line-buffer path.
// DINT_LINE_LEN is also the wrap size (MAX_SIZE) of the FIFO_1K banks.
package dint_pkg;

    localparam int DINT_LINE_LEN = 10;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        DRAIN
    } lpc_state_t;

endpackage

// File: rtl/line_cnt.sv
// Pixel position counter for one line: synchronous clear has priority over enable,
// term flags that the next enabled count completes the line.
module line_cnt
    import dint_pkg::*;
#(
    parameter int LINE_LEN = DINT_LINE_LEN,
    parameter int CNT_W    = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             term
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign term = (cnt == CNT_W'(LINE_LEN - 1));

endmodule

// File: rtl/line_pingpong_ctrl.sv
// Ping-pong sequencer for the two line-buffer FIFOs: one bank is written while the
// other is replayed REPEAT times, then the banks swap after a single bubble cycle.
module line_pingpong_ctrl
    import dint_pkg::*;
#(
    parameter  int LINE_LEN = DINT_LINE_LEN,
    parameter  int CNT_W    = 10,
    parameter  int REPEAT   = 2,
    localparam int PW       = (REPEAT > 1) ? $clog2(REPEAT) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          out_ready,
    output logic          out_valid,
    input  logic          flush,
    output logic          wr_req_a,
    output logic          wr_req_b,
    output logic          rd_req_a,
    output logic          rd_req_b,
    output logic          empty_en_a,
    output logic          empty_en_b,
    output logic          bank_wr,
    output logic [PW-1:0] pass_idx,
    output logic          line_start
);

    localparam logic [PW-1:0] LAST_PASS = PW'(REPEAT - 1);

    lpc_state_t       state;
    lpc_state_t       state_next;
    logic             wdone;
    logic             rdone;
    logic             flush_pend;
    logic [PW-1:0]    pass;
    logic [CNT_W-1:0] rcnt;
    logic [CNT_W-1:0] wcnt_unused;
    logic             w_last;
    logic             r_last;
    logic             filling;
    logic             reading;
    logic             wr_acc;
    logic             rd_acc;
    logic             last_pass;
    logic             swap;
    logic             drain_end;
    logic             rcnt_clr;
    logic             wcnt_clr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The read bank is always ~bank_wr, including DRAIN, because entering DRAIN
    // also toggles bank_wr so the freshly written line becomes the read bank.
    always_comb begin
        state_next = state;
        filling    = (state == FILL) || (state == RUN);
        reading    = (state == RUN) || (state == DRAIN);
        in_ready   = filling && !wdone;
        out_valid  = reading && !rdone;
        wr_acc     = in_valid && in_ready;
        rd_acc     = out_valid && out_ready;
        wr_req_a   = wr_acc && !bank_wr;
        wr_req_b   = wr_acc && bank_wr;
        rd_req_a   = rd_acc && bank_wr;
        rd_req_b   = rd_acc && !bank_wr;
        last_pass  = (pass == LAST_PASS);
        empty_en_a = out_valid && bank_wr && last_pass;
        empty_en_b = out_valid && !bank_wr && last_pass;
        line_start = out_valid && (rcnt == '0);
        pass_idx   = pass;
        swap       = ((state == FILL) && wdone) || ((state == RUN) && wdone && rdone);
        drain_end  = (state == DRAIN) && rdone;
        wcnt_clr   = swap || drain_end;
        rcnt_clr   = swap || drain_end || (rd_acc && r_last);

        case (state)
            IDLE:    if (in_valid)  state_next = FILL;
            FILL:    if (swap)      state_next = flush_pend ? DRAIN : RUN;
            RUN:     if (swap)      state_next = flush_pend ? DRAIN : RUN;
            DRAIN:   if (drain_end) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // A swap into DRAIN keeps wdone high so the write side stays blocked.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bank_wr    <= 1'b0;
            wdone      <= 1'b0;
            rdone      <= 1'b0;
            pass       <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (swap) begin
                bank_wr <= !bank_wr;
            end

            if (drain_end || (swap && !flush_pend)) begin
                wdone <= 1'b0;
            end else if (wr_acc && w_last) begin
                wdone <= 1'b1;
            end

            if (swap || drain_end) begin
                rdone <= 1'b0;
                pass  <= '0;
            end else if (rd_acc && r_last) begin
                if (last_pass) begin
                    rdone <= 1'b1;
                end else begin
                    pass <= pass + 1'b1;
                end
            end

            if (swap && flush_pend) begin
                flush_pend <= 1'b0;
            end else if (flush && filling) begin
                flush_pend <= 1'b1;
            end
        end
    end

    line_cnt #(
        .LINE_LEN (LINE_LEN),
        .CNT_W    (CNT_W)
    ) u_wcnt (
        .clock (clock),
        .reset (reset),
        .en    (wr_acc),
        .clr   (wcnt_clr),
        .cnt   (wcnt_unused),
        .term  (w_last)
    );

    line_cnt #(
        .LINE_LEN (LINE_LEN),
        .CNT_W    (CNT_W)
    ) u_rcnt (
        .clock (clock),
        .reset (reset),
        .en    (rd_acc),
        .clr   (rcnt_clr),
        .cnt   (rcnt),
        .term  (r_last)
    );

endmodule

// File: tb/tb_line_pingpong_ctrl.sv
// Directed bench for line_pingpong_ctrl; a scoreboard queue holds the expected
// replay of every completed line and is drained by the read strobes.
module tb_line_pingpong_ctrl;
    import dint_pkg::*;

    localparam int LINE_LEN = 10;
    localparam int REPEAT   = 2;
    localparam int PW       = 1;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          out_ready;
    logic          out_valid;
    logic          flush;
    logic          wr_req_a;
    logic          wr_req_b;
    logic          rd_req_a;
    logic          rd_req_b;
    logic          empty_en_a;
    logic          empty_en_b;
    logic          bank_wr;
    logic [PW-1:0] pass_idx;
    logic          line_start;

    typedef struct packed {
        logic          bank;
        logic          first;
        logic [PW-1:0] pass;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    logic    exp_wr_bank;
    int      line_w;
    int      tests_run = 0;
    int      fail_cnt  = 0;

    line_pingpong_ctrl #(
        .LINE_LEN (LINE_LEN),
        .CNT_W    (10),
        .REPEAT   (REPEAT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .flush      (flush),
        .wr_req_a   (wr_req_a),
        .wr_req_b   (wr_req_b),
        .rd_req_a   (rd_req_a),
        .rd_req_b   (rd_req_b),
        .empty_en_a (empty_en_a),
        .empty_en_b (empty_en_b),
        .bank_wr    (bank_wr),
        .pass_idx   (pass_idx),
        .line_start (line_start)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({in_ready, out_valid, wr_req_a, wr_req_b, rd_req_a, rd_req_b,
                    empty_en_a, empty_en_b, bank_wr, pass_idx, line_start});
    endfunction

    // Bank encoding in the model: 0 = A, 1 = B. A completed line schedules
    // REPEAT back-to-back replays of its pixels from the bank it was written to.
    always @(negedge clock) begin : monitor
        rd_exp_t    e;
        logic [1:0] ee;
        if (reset) begin
            exp_q.delete();
            line_w      = 0;
            exp_wr_bank = 1'b0;
        end else begin
            if (rd_req_a || rd_req_b) begin
                check_output("rd_needs_ready", 32'(out_ready), 1);
                check_output("rd_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e  = exp_q.pop_front();
                    ee = (e.pass == PW'(REPEAT - 1)) ? (e.bank ? 2'b01 : 2'b10) : 2'b00;
                    check_output("rd_bank", 32'(rd_req_b), 32'(e.bank));
                    check_output("line_start", 32'(line_start), 32'(e.first));
                    check_output("pass_idx", 32'(pass_idx), 32'(e.pass));
                    check_output("empty_en", 32'({empty_en_a, empty_en_b}), 32'(ee));
                end
            end
            if (wr_req_a || wr_req_b) begin
                check_output("wr_one_hot", 32'(wr_req_a && wr_req_b), 0);
                check_output("wr_bank", 32'(wr_req_b), 32'(exp_wr_bank));
                if (rd_req_a || rd_req_b) begin
                    check_output("wr_rd_bank_differ", 32'(wr_req_b != rd_req_b), 1);
                end
                line_w++;
                if (line_w == LINE_LEN) begin
                    for (int p = 0; p < REPEAT; p++) begin
                        for (int k = 0; k < LINE_LEN; k++) begin
                            exp_q.push_back('{bank: exp_wr_bank, first: (k == 0), pass: PW'(p)});
                        end
                    end
                    line_w      = 0;
                    exp_wr_bank = !exp_wr_bank;
                end
            end
        end
    end

    task automatic apply_stimulus(input int mode, input int n, input int flush_at);
        case (mode)
            1:       begin in_valid = 1'b1;                     out_ready = ((n % 2) == 0); end
            2:       begin in_valid = 1'($urandom_range(0, 1)); out_ready = 1'b1;           end
            3:       begin in_valid = (n >= 10);                out_ready = 1'b1;           end
            default: begin in_valid = 1'b1;                     out_ready = 1'b1;           end
        endcase
        flush = (n == flush_at);
    endtask

    task automatic apply_reset();
        @(posedge clock); #1;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    // Runs cycles until bank_wr changes; counts strobes and both-idle bubble cycles.
    task automatic run_line(input int mode, input int flush_at,
                            output int wa, output int wb, output int ra, output int rb,
                            output int bub, output int irl, output logic timed_out);
        logic start_bank;
        int   n;
        start_bank = bank_wr;
        n = 0; wa = 0; wb = 0; ra = 0; rb = 0; bub = 0; irl = 0;
        timed_out = 1'b0;
        while (bank_wr == start_bank) begin
            if (n >= 200) begin
                timed_out = 1'b1;
                break;
            end
            apply_stimulus(mode, n, flush_at);
            @(negedge clock);
            wa += int'(wr_req_a);
            wb += int'(wr_req_b);
            ra += int'(rd_req_a);
            rb += int'(rd_req_b);
            if ((wa + wb) > 0 && !in_ready && !out_valid) bub++;
            if (!in_ready && (rd_req_a || rd_req_b)) irl++;
            @(posedge clock); #1;
            n++;
        end
        flush = 1'b0;
    endtask

    task automatic expect_line(input string tag, input int mode, input int flush_at,
                               input logic w_bank, input int exp_reads, input logic r_bank,
                               output int irl);
        int   wa, wb, ra, rb, bub;
        logic to;
        run_line(mode, flush_at, wa, wb, ra, rb, bub, irl, to);
        check_output({tag, ":timeout"}, 32'(to), 0);
        check_output({tag, ":writes"}, w_bank ? wb : wa, LINE_LEN);
        check_output({tag, ":stray_writes"}, w_bank ? wa : wb, 0);
        check_output({tag, ":reads"}, r_bank ? rb : ra, exp_reads);
        check_output({tag, ":stray_reads"}, r_bank ? ra : rb, 0);
        check_output({tag, ":bubbles"}, bub, 1);
    endtask

    initial begin
        int irl;
        int n;
        int rds;
        int wrs;
        int ra;
        int rb;
        int ir_high;
        int last_rd;
        int idle_at;

        reset     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        flush     = 1'b0;

        // Test 1: free-flowing stream from reset.
        @(negedge clock);
        check_output("t1:reset_outputs", out_vec(), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        #3;
        check_output("t1:idle_in_ready", 32'(in_ready), 0);
        expect_line("t1_line1", 0, -1, 1'b0, 0, 1'b0, irl);
        check_output("t1:bank_after_fill", 32'(bank_wr), 1);
        expect_line("t1_line2", 0, -1, 1'b1, 2 * LINE_LEN, 1'b0, irl);
        check_output("t1:in_ready_low_reads", irl, LINE_LEN);

        // Test 2: out_ready toggling 1,0,1,0.
        expect_line("t2_line3", 1, -1, 1'b0, 2 * LINE_LEN, 1'b1, irl);
        expect_line("t2_line4", 1, -1, 1'b1, 2 * LINE_LEN, 1'b0, irl);

        // Test 5: writes stalled so the last write meets the last read.
        expect_line("t5_line5", 3, -1, 1'b0, 2 * LINE_LEN, 1'b1, irl);
        check_output("t5:in_ready_low_reads", irl, 0);
        check_output("t5:bank_swapped", 32'(bank_wr), 1);
        check_output("t5:pass_cleared", 32'(pass_idx), 0);
        check_output("t5:rcnt_cleared", 32'(line_start), 1);
        check_output("t5:wcnt_cleared", 32'(in_ready), 1);

        // Test 3: flush during the third line, then drain.
        apply_reset();
        expect_line("t3_line1", 0, -1, 1'b0, 0, 1'b0, irl);
        expect_line("t3_line2", 0, -1, 1'b1, 2 * LINE_LEN, 1'b0, irl);
        expect_line("t3_line3", 0, 3, 1'b0, 2 * LINE_LEN, 1'b1, irl);
        n = 0; ra = 0; rb = 0; wrs = 0; ir_high = 0; last_rd = -1; idle_at = -1;
        while (n < 100) begin
            in_valid  = 1'b1;
            out_ready = 1'b1;
            @(negedge clock);
            if (dut.state == IDLE) begin
                idle_at = n;
                break;
            end
            ra      += int'(rd_req_a);
            rb      += int'(rd_req_b);
            wrs     += int'(wr_req_a || wr_req_b);
            ir_high += int'(in_ready);
            if (rd_req_a || rd_req_b) last_rd = n;
            @(posedge clock); #1;
            n++;
        end
        in_valid = 1'b0;
        check_output("t3:drain_reached_idle", 32'(idle_at >= 0), 1);
        check_output("t3:drain_reads_a", ra, 2 * LINE_LEN);
        check_output("t3:drain_reads_b", rb, 0);
        check_output("t3:drain_writes", wrs, 0);
        check_output("t3:drain_in_ready", ir_high, 0);
        check_output("t3:idle_delay", idle_at - last_rd, 2);

        // Test 4: asynchronous reset mid-RUN at rcnt=5, pass=1.
        apply_reset();
        expect_line("t4_line1", 0, -1, 1'b0, 0, 1'b0, irl);
        expect_line("t4_line2", 0, -1, 1'b1, 2 * LINE_LEN, 1'b0, irl);
        n = 0; rds = 0;
        while (rds < 15 && n < 100) begin
            in_valid  = 1'b1;
            out_ready = 1'b1;
            @(negedge clock);
            rds += int'(rd_req_a || rd_req_b);
            @(posedge clock); #1;
            n++;
        end
        check_output("t4:reads_before_reset", rds, 15);
        check_output("t4:pass_before_reset", 32'(pass_idx), 1);
        #2;
        reset = 1'b1;
        #1;
        check_output("t4:async_outputs", out_vec(), 0);
        @(posedge clock); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b0;
        @(negedge clock);
        check_output("t4:state_idle", 32'(dut.state), 32'(IDLE));
        check_output("t4:bank_wr", 32'(bank_wr), 0);
        check_output("t4:outputs_idle", out_vec(), 0);
        @(posedge clock); #1;

        // Test 6: random input gaps over four lines.
        expect_line("t6_line1", 2, -1, 1'b0, 0, 1'b0, irl);
        expect_line("t6_line2", 2, -1, 1'b1, 2 * LINE_LEN, 1'b0, irl);
        expect_line("t6_line3", 2, -1, 1'b0, 2 * LINE_LEN, 1'b1, irl);
        expect_line("t6_line4", 2, -1, 1'b1, 2 * LINE_LEN, 1'b0, irl);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
